sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, SDRAM word address width.
REQ-002 SHALL have parameter LEN_W, default 8, burst length field width (words minus one).
REQ-003 SHALL have parameter REFRESH_CYCLES, default 780, clk_draw cycles between refresh ticks.
REQ-004 SHALL have port clk_draw  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_draw  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  in  3  per-requester request; bit 0 display fetch, bit 1 draw write, bit 2 draw read.
REQ-007 SHALL have port req_ready  out  3  per-requester accept strobe.
REQ-008 SHALL have port req_we  in  3  per-requester write flag.
REQ-009 SHALL have port req_addr  in  3*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port req_len  in  3*LEN_W  per-requester burst length, packed as req_addr.
REQ-011 SHALL have port cmd_valid  out  1  command to SDRAM controller valid.
REQ-012 SHALL have port cmd_ready  in  1  controller accepts command.
REQ-013 SHALL have ports cmd_we (out 1), cmd_refresh (out 1), cmd_addr (out ADDR_W), cmd_len (out LEN_W): registered command fields.
REQ-014 SHALL have port cmd_done  in  1  single-cycle pulse when the accepted command completes.
REQ-015 SHALL have ports grant_id  out  2  current owner (0-2 requester, 3 refresh), and busy  out  1  high when not IDLE.
REQ-016 SHALL have port ref_overflow  out  1  sticky: refresh backlog saturated.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT; IDLE->ISSUE on any pending request or refresh; ISSUE->WAIT on cmd_valid&&cmd_ready; WAIT->IDLE on cmd_done.
REQ-018 SHALL arbitrate only in IDLE, priority: pending refresh > requester 0 > round-robin between 1 and 2.
REQ-019 SHALL toggle the round-robin pointer only when requester 1 or 2 wins; after reset requester 1 is preferred.
REQ-020 SHALL register cmd fields and grant_id on the IDLE->ISSUE edge, so cmd_valid rises one cycle after req_valid is sampled in IDLE.
REQ-021 SHALL drive a refresh command as cmd_refresh=1, cmd_we=0, cmd_addr=0, cmd_len=0.
REQ-022 SHALL assert req_ready[i] combinationally only when state is ISSUE, grant_id==i, and cmd_ready is high; requesters hold valid and fields until then.
REQ-023 SHALL hold cmd_valid and all cmd fields stable in ISSUE until cmd_ready.
REQ-024 SHALL ignore cmd_done outside WAIT.
REQ-025 SHALL run a free refresh down-counter reloading REFRESH_CYCLES-1 on reaching 0; each zero is a tick.
REQ-026 SHALL keep a 3-bit refresh backlog: +1 per tick, -1 on cmd_done of a refresh command; simultaneous tick and refresh done leaves it unchanged.
REQ-027 SHALL saturate the backlog at 7, setting ref_overflow on a tick at 7; ref_overflow clears only on reset.
REQ-028 SHALL let refresh wait for an in-flight transfer; no preemption after IDLE.

Reset
REQ-029 SHALL, on rst_draw, immediately set state IDLE, cmd_valid=0, req_ready=0, cmd fields 0, grant_id=0, busy=0, backlog=0, ref_overflow=0, round-robin to requester 1, counter to REFRESH_CYCLES-1.
REQ-030 SHALL, on reset mid-transfer, abandon the command without a done wait; the first post-reset grant follows normal arbitration.

Verification
REQ-031 SHALL cover: req_valid=3'b111, no refresh due -> grants 0, then 1, then 2, then 1 (with 1 and 2 held).
REQ-032 SHALL cover: REFRESH_CYCLES=16, requester 0 held continuously -> cmd_refresh=1 in the first IDLE after cycle 16; grant_id=3.
REQ-033 SHALL cover: cmd_ready low for 5 cycles in ISSUE -> cmd fields stable, req_ready=0, then a one-cycle req_ready with cmd_ready.
REQ-034 SHALL cover: cmd_done stuck low over 8 ticks -> backlog 7, ref_overflow=1, then 7 refreshes follow the release.
REQ-035 SHALL cover: rst_draw asserted in WAIT -> outputs at reset values before the next clock edge.
REQ-036 SHALL cover: tick coincident with a refresh cmd_done at backlog 1 -> backlog stays 1.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Three-requester SDRAM command arbiter with periodic refresh insertion.
//   Requester 0 is the display fetch, 1 the draw write and 2 the draw read.
//   Arbitration happens only in IDLE. A pending refresh wins first, then
//   requester 0, then requesters 1 and 2 alternate round-robin. The winning
//   command is registered, offered to the controller in ISSUE, and the arbiter
//   then sits in WAIT until the controller reports completion.
//
// Ports
//   clk_draw       in   sole clock, rising edge
//   rst_draw       in   asynchronous active-high reset
//   req_valid[2:0] in   per-requester request
//   req_ready[2:0] out  per-requester accept strobe (ISSUE && owner && cmd_ready)
//   req_we[2:0]    in   per-requester write flag
//   req_addr       in   3*ADDR_W, requester i at [i*ADDR_W +: ADDR_W]
//   req_len        in   3*LEN_W, burst length minus one, packed like req_addr
//   cmd_valid      out  command valid towards the SDRAM controller
//   cmd_ready      in   controller accepts the command
//   cmd_we         out  registered write flag
//   cmd_refresh    out  registered refresh flag
//   cmd_addr       out  registered word address
//   cmd_len        out  registered burst length
//   cmd_done       in   one-cycle pulse when the accepted command completes
//   grant_id[1:0]  out  current owner: 0-2 requester, 3 refresh
//   busy           out  high whenever the arbiter is not IDLE
//   ref_overflow   out  sticky, refresh backlog saturated
module sdram_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int LEN_W          = 8,
  parameter int REFRESH_CYCLES = 780
) (
  input  logic                  clk_draw,
  input  logic                  rst_draw,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*LEN_W-1:0]    req_len,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_we,
  output logic                  cmd_refresh,
  output logic [ADDR_W-1:0]     cmd_addr,
  output logic [LEN_W-1:0]      cmd_len,
  input  logic                  cmd_done,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic                  ref_overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [1:0] GNT_REFRESH = 2'd3;

  localparam int              CNT_W      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);

  logic [1:0]        state_q,   state_d;
  logic [1:0]        grant_q,   grant_d;
  logic              we_q,      we_d;
  logic              refresh_q, refresh_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [LEN_W-1:0]  len_q,     len_d;
  logic              rr_q,      rr_d;      // 0: prefer requester 1, 1: prefer requester 2
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [2:0]        backlog_q, backlog_d;
  logic              ovf_q,     ovf_d;

  logic              win_valid;
  logic [1:0]        win_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;
  logic              rr_next;

  logic              tick;
  logic              ref_done;

  // ---------------------------------------------------------------------------
  // Arbitration. Evaluated every cycle but only consumed in IDLE.
  // A refresh command carries all-zero fields, which the defaults provide.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_valid = 1'b0;
    win_id    = GNT_REFRESH;
    win_we    = 1'b0;
    win_addr  = '0;
    win_len   = '0;
    rr_next   = rr_q;
    if (backlog_q != 3'd0) begin
      win_valid = 1'b1;
    end else if (req_valid[0]) begin
      win_valid = 1'b1;
      win_id    = 2'd0;
      win_we    = req_we[0];
      win_addr  = req_addr[0*ADDR_W +: ADDR_W];
      win_len   = req_len[0*LEN_W +: LEN_W];
    end else if (req_valid[1] && (!rr_q || !req_valid[2])) begin
      win_valid = 1'b1;
      win_id    = 2'd1;
      win_we    = req_we[1];
      win_addr  = req_addr[1*ADDR_W +: ADDR_W];
      win_len   = req_len[1*LEN_W +: LEN_W];
      rr_next   = ~rr_q;
    end else if (req_valid[2]) begin
      win_valid = 1'b1;
      win_id    = 2'd2;
      win_we    = req_we[2];
      win_addr  = req_addr[2*ADDR_W +: ADDR_W];
      win_len   = req_len[2*LEN_W +: LEN_W];
      rr_next   = ~rr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM. Fields and owner are captured on the IDLE->ISSUE edge and
  // held untouched through ISSUE and WAIT. cmd_done only matters in WAIT.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    we_d      = we_q;
    refresh_d = refresh_q;
    addr_d    = addr_q;
    len_d     = len_q;
    rr_d      = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d   = ST_ISSUE;
          grant_d   = win_id;
          we_d      = win_we;
          refresh_d = (win_id == GNT_REFRESH);
          addr_d    = win_addr;
          len_d     = win_len;
          rr_d      = rr_next;
        end
      end
      ST_ISSUE: if (cmd_ready) state_d = ST_WAIT;
      ST_WAIT:  if (cmd_done)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Refresh timing. The free-running down-counter ticks each time it hits
  // zero. The backlog counts owed refreshes including the one in flight, so
  // it only drops when a refresh command completes.
  // ---------------------------------------------------------------------------
  assign tick     = (cnt_q == '0);
  assign ref_done = (state_q == ST_WAIT) && cmd_done && refresh_q;
  assign cnt_d    = tick ? CNT_RELOAD : cnt_q - 1'b1;

  always_comb begin
    backlog_d = backlog_q;
    ovf_d     = ovf_q;
    if (tick && !ref_done) begin
      if (backlog_q == 3'd7) ovf_d     = 1'b1;
      else                   backlog_d = backlog_q + 3'd1;
    end else if (ref_done && !tick && (backlog_q != 3'd0)) begin
      backlog_d = backlog_q - 3'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'd0;
      we_q      <= 1'b0;
      refresh_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      rr_q      <= 1'b0;
      cnt_q     <= CNT_RELOAD;
      backlog_q <= 3'd0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      refresh_q <= refresh_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      backlog_q <= backlog_d;
      ovf_q     <= ovf_d;
    end
  end

  // Accept strobe is combinational on cmd_ready so the requester sees it in
  // the same cycle the controller takes the command. A refresh owner has no
  // requester to strobe.
  always_comb begin
    req_ready = 3'b000;
    if ((state_q == ST_ISSUE) && cmd_ready && (grant_q != GNT_REFRESH))
      req_ready = 3'b001 << grant_q;
  end

  assign cmd_valid    = (state_q == ST_ISSUE);
  assign cmd_we       = we_q;
  assign cmd_refresh  = refresh_q;
  assign cmd_addr     = addr_q;
  assign cmd_len      = len_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter with REFRESH_CYCLES=16. After each reset
//   release (on a falling edge) the refresh ticks land on rising edges 16, 32,
//   48, ... counted from that release, so every expected cycle below is
//   counted from the most recent reset.
module tb_sdram_arbiter;

  localparam int AW = 24;
  localparam int LW = 8;
  localparam int RC = 16;

  logic              clk_draw = 1'b0;
  logic              rst_draw = 1'b1;
  logic [2:0]        req_valid = 3'b000;
  logic [2:0]        req_ready;
  logic [2:0]        req_we = 3'b010;
  logic [3*AW-1:0]   req_addr = '0;
  logic [3*LW-1:0]   req_len = '0;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic              cmd_we;
  logic              cmd_refresh;
  logic [AW-1:0]     cmd_addr;
  logic [LW-1:0]     cmd_len;
  logic              cmd_done = 1'b0;
  logic [1:0]        grant_id;
  logic              busy;
  logic              ref_overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [AW-1:0] addr_tab [3];
  logic [LW-1:0] len_tab  [3];

  always #5 clk_draw = ~clk_draw;

  sdram_arbiter #(
    .ADDR_W        (AW),
    .LEN_W         (LW),
    .REFRESH_CYCLES(RC)
  ) dut (
    .clk_draw    (clk_draw),
    .rst_draw    (rst_draw),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_refresh (cmd_refresh),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_done    (cmd_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .ref_overflow(ref_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_draw);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_fields();
    req_addr = {addr_tab[2], addr_tab[1], addr_tab[0]};
    req_len  = {len_tab[2], len_tab[1], len_tab[0]};
  endtask

  // Reset for one rising edge and release on the following falling edge, so
  // the next rising edge is edge 1.
  task automatic do_reset();
    rst_draw = 1'b1;
    @(posedge clk_draw);
    #1;
    @(negedge clk_draw);
    rst_draw = 1'b0;
  endtask

  // Starting in IDLE with cmd_ready high: one edge to ISSUE (checked), one
  // edge to WAIT, one edge with cmd_done back to IDLE.
  task automatic serve(input string tag, input logic [1:0] gid);
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_len;
    logic [2:0]    e_rdy;
    if (gid == 2'd3) begin
      e_we = 1'b0; e_addr = '0; e_len = '0; e_rdy = 3'b000;
    end else begin
      e_we   = req_we[gid];
      e_addr = addr_tab[gid];
      e_len  = len_tab[gid];
      e_rdy  = 3'b001 << gid;
    end
    step();
    check({tag, " grant_id"},    32'(grant_id),    32'(gid));
    check({tag, " cmd_valid"},   32'(cmd_valid),   32'd1);
    check({tag, " cmd_refresh"}, 32'(cmd_refresh), 32'(gid == 2'd3));
    check({tag, " cmd_we"},      32'(cmd_we),      32'(e_we));
    check({tag, " cmd_addr"},    32'(cmd_addr),    32'(e_addr));
    check({tag, " cmd_len"},     32'(cmd_len),     32'(e_len));
    check({tag, " req_ready"},   32'(req_ready),   32'(e_rdy));
    step();
    check({tag, " wait cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, " wait req_ready"}, 32'(req_ready), 32'd0);
    check({tag, " wait busy"},      32'(busy),      32'd1);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    check({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] saved;

    addr_tab[0] = 24'h10_0A00; len_tab[0] = 8'h3F;
    addr_tab[1] = 24'h22_1B10; len_tab[1] = 8'h07;
    addr_tab[2] = 24'h33_2C20; len_tab[2] = 8'h0F;
    load_fields();
    cmd_ready = 1'b1;

    // Reset state while reset is held.
    @(posedge clk_draw);
    #1;
    check("rst cmd_valid",    32'(cmd_valid),    32'd0);
    check("rst req_ready",    32'(req_ready),    32'd0);
    check("rst busy",         32'(busy),         32'd0);
    check("rst grant_id",     32'(grant_id),     32'd0);
    check("rst cmd_addr",     32'(cmd_addr),     32'd0);
    check("rst cmd_refresh",  32'(cmd_refresh),  32'd0);
    check("rst ref_overflow", 32'(ref_overflow), 32'd0);

    // All three requesting: 0 first, then 1/2 alternate starting with 1.
    req_valid = 3'b111;
    do_reset();
    serve("rr0", 2'd0);
    req_valid = 3'b110;
    serve("rr1", 2'd1);
    serve("rr2", 2'd2);
    serve("rr3", 2'd1);
    req_valid = 3'b000;

    // Requester 0 held: five grants through edge 15, a sixth at edge 16 (the
    // tick lands on that edge), then the refresh at edge 19, then 0 again.
    req_valid = 3'b001;
    do_reset();
    for (int i = 0; i < 6; i++) serve("hold0", 2'd0);
    serve("refresh", 2'd3);
    serve("after_refresh", 2'd0);
    req_valid = 3'b000;

    // Controller stalls five cycles in ISSUE; fields stay registered even if
    // the requester's inputs move, and a stray cmd_done is ignored.
    cmd_ready = 1'b0;
    req_valid = 3'b010;
    do_reset();
    step();
    check("stall grant_id",  32'(grant_id),  32'd1);
    check("stall cmd_valid", 32'(cmd_valid), 32'd1);
    check("stall req_ready", 32'(req_ready), 32'd0);
    saved       = addr_tab[1];
    addr_tab[1] = 24'h5A_5A5A;
    load_fields();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) cmd_done = 1'b1;
      step();
      cmd_done = 1'b0;
      check("stall hold cmd_valid", 32'(cmd_valid), 32'd1);
      check("stall hold cmd_addr",  32'(cmd_addr),  32'(saved));
      check("stall hold req_ready", 32'(req_ready), 32'd0);
    end
    cmd_ready = 1'b1;
    #1;
    check("stall accept req_ready", 32'(req_ready), 32'b010);
    step();
    cmd_ready = 1'b0;
    check("stall after req_ready", 32'(req_ready), 32'd0);
    check("stall after cmd_valid", 32'(cmd_valid), 32'd0);
    check("stall after cmd_addr",  32'(cmd_addr),  32'(saved));
    check("stall after busy",      32'(busy),      32'd1);
    req_valid   = 3'b000;
    addr_tab[1] = saved;
    load_fields();
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    check("stall done busy", 32'(busy), 32'd0);

    // Reset asserted mid-WAIT. Requester 1 wins first so the pointer moves
    // to 2; after reset requester 1 must win again.
    cmd_ready = 1'b1;
    req_valid = 3'b010;
    do_reset();
    steps(2);
    req_valid = 3'b000;
    check("midrst pre busy", 32'(busy), 32'd1);
    #2;
    rst_draw = 1'b1;
    #1;
    check("midrst busy",        32'(busy),        32'd0);
    check("midrst cmd_valid",   32'(cmd_valid),   32'd0);
    check("midrst req_ready",   32'(req_ready),   32'd0);
    check("midrst grant_id",    32'(grant_id),    32'd0);
    check("midrst cmd_addr",    32'(cmd_addr),    32'd0);
    check("midrst cmd_len",     32'(cmd_len),     32'd0);
    check("midrst cmd_we",      32'(cmd_we),      32'd0);
    check("midrst cmd_refresh", 32'(cmd_refresh), 32'd0);
    @(negedge clk_draw);
    rst_draw  = 1'b0;
    req_valid = 3'b110;
    serve("postrst", 2'd1);
    req_valid = 3'b000;

    // Refresh issued at edge 17 and stuck in WAIT. Ticks at 32..112 take the
    // backlog to 7; the tick at 128 overflows. After release the in-flight
    // refresh completes (backlog 6), the tick at edge 144 coincides with a
    // refresh done, and seven more refreshes drain it by edge 150.
    do_reset();
    steps(16);
    check("ovf idle before refresh", 32'(busy), 32'd0);
    step();
    check("ovf first grant",   32'(grant_id),    32'd3);
    check("ovf first refresh", 32'(cmd_refresh), 32'd1);
    step();
    check("ovf stuck busy", 32'(busy), 32'd1);
    steps(109);
    check("ovf before saturate", 32'(ref_overflow), 32'd0);
    step();
    check("ovf set",        32'(ref_overflow), 32'd1);
    check("ovf still busy", 32'(busy),         32'd1);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    check("ovf release idle", 32'(busy), 32'd0);
    for (int i = 0; i < 7; i++) serve("drain", 2'd3);
    step();
    check("ovf drained busy", 32'(busy),         32'd0);
    check("ovf sticky",       32'(ref_overflow), 32'd1);

    // Tick at edge 32 coincides with the done of a refresh at backlog 1:
    // one refresh is still owed, then nothing.
    do_reset();
    check("coin ovf cleared", 32'(ref_overflow), 32'd0);
    steps(17);
    check("coin first refresh", 32'(cmd_refresh), 32'd1);
    steps(14);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    check("coin done idle", 32'(busy), 32'd0);
    step();
    check("coin owed grant",   32'(grant_id),    32'd3);
    check("coin owed refresh", 32'(cmd_refresh), 32'd1);
    check("coin owed valid",   32'(cmd_valid),   32'd1);
    step();
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    steps(2);
    check("coin settled busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
